xram_arbiter: RTL and testbench

Two-master, single-port arbiter between the 8051 XRAM bus and the AES accelerator's XRAM master port, in front of the shared synchronous XRAM array. It consumes every AES read/write strobe, serializes it against CPU XRAM traffic, and drives the one-cycle-read-latency RAM with a configurable number of wait states. It returns the one-cycle `ack` pulse the AES byte counter advances on.

---
 rtl/xram_arbiter_if.sv | 47 ++++
 rtl/xram_arbiter.sv | 131 +++++++++++++
 tb/tb_xram_arbiter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/xram_arbiter_if.sv
// rtl/xram_arbiter_if.sv - CPU, AES and RAM-side signals of the XRAM arbiter
// The slave modport is the arbiter's view; the master modport is its environment.
interface xram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] cpu_addr;
    logic [7:0]        cpu_wdata;
    logic [7:0]        cpu_rdata;
    logic              cpu_wr;
    logic              cpu_stb;
    logic              cpu_ack;

    logic [ADDR_W-1:0] aes_xram_addr;
    logic [7:0]        aes_xram_wdata;
    logic [7:0]        aes_xram_rdata;
    logic              aes_xram_wr;
    logic              aes_xram_stb;
    logic              aes_xram_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_en;
    logic              mem_we;

    logic [1:0]        gnt;

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_wr, cpu_stb,
        output cpu_rdata, cpu_ack,
        input  aes_xram_addr, aes_xram_wdata, aes_xram_wr, aes_xram_stb,
        output aes_xram_rdata, aes_xram_ack,
        output mem_addr, mem_wdata, mem_en, mem_we,
        input  mem_rdata,
        output gnt
    );

    modport master (
        output cpu_addr, cpu_wdata, cpu_wr, cpu_stb,
        input  cpu_rdata, cpu_ack,
        output aes_xram_addr, aes_xram_wdata, aes_xram_wr, aes_xram_stb,
        input  aes_xram_rdata, aes_xram_ack,
        input  mem_addr, mem_wdata, mem_en, mem_we,
        output mem_rdata,
        input  gnt
    );
endinterface

// File: rtl/xram_arbiter.sv
// rtl/xram_arbiter.sv - two-master (CPU/AES) arbiter in front of a single-port synchronous XRAM
// Define XRAM_ARB_RR_EN for round-robin tie-breaking; otherwise the CPU has fixed priority.
module xram_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    xram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] LP_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_gnt, w_gnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [7:0]        r_wdata, w_wdata_nxt;
    logic              r_mem_en, w_mem_en_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              w_any_req;
    logic              w_pick_aes;
    logic              w_in_ack;

    assign w_any_req = bus.cpu_stb | bus.aes_xram_stb;

`ifdef XRAM_ARB_RR_EN
    logic r_last_aes;

    // On a tie the master that did not win last time gets the grant.
    assign w_pick_aes = bus.aes_xram_stb & (~bus.cpu_stb | ~r_last_aes);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_aes <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_aes <= w_pick_aes;
        end
    end
`else
    assign w_pick_aes = bus.aes_xram_stb & ~bus.cpu_stb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_gnt    <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= 8'h00;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_cnt    <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_mem_en <= w_mem_en_nxt;
            r_mem_we <= w_mem_we_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_mem_en_nxt = 1'b0;
        w_mem_we_nxt = 1'b0;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                // The winner's request is captured straight into the RAM-side registers.
                if (w_any_req) begin
                    w_state_nxt  = S_ACCESS;
                    w_mem_en_nxt = 1'b1;
                    if (w_pick_aes) begin
                        w_gnt_nxt    = 2'b10;
                        w_addr_nxt   = bus.aes_xram_addr;
                        w_wdata_nxt  = bus.aes_xram_wdata;
                        w_mem_we_nxt = bus.aes_xram_wr;
                    end else begin
                        w_gnt_nxt    = 2'b01;
                        w_addr_nxt   = bus.cpu_addr;
                        w_wdata_nxt  = bus.cpu_wdata;
                        w_mem_we_nxt = bus.cpu_wr;
                    end
                end
            end
            S_ACCESS: begin
                if (WAIT_CYCLES > 0) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = LP_WAIT_LOAD;
                end else begin
                    w_state_nxt = S_ACK;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
            end
        endcase
    end

    // A master that dropped its strobe after grant gets no ack; the RAM access still happened.
    assign w_in_ack           = (r_state == S_ACK);
    assign bus.cpu_ack        = w_in_ack & r_gnt[0] & bus.cpu_stb;
    assign bus.aes_xram_ack   = w_in_ack & r_gnt[1] & bus.aes_xram_stb;
    assign bus.cpu_rdata      = (w_in_ack & r_gnt[0]) ? bus.mem_rdata : 8'h00;
    assign bus.aes_xram_rdata = (w_in_ack & r_gnt[1]) ? bus.mem_rdata : 8'h00;

    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.gnt       = r_gnt;
endmodule

// File: tb/tb_xram_arbiter.sv
// tb/tb_xram_arbiter.sv - directed bench for xram_arbiter with WAIT_CYCLES 0 and 2
// RAM contents default to a fixed address pattern; reads are scoreboarded.
module tb_xram_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xram_arbiter_if #(.ADDR_W(16)) b0 ();
    xram_arbiter_if #(.ADDR_W(16)) b2 ();

    xram_arbiter #(.ADDR_W(16), .WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    xram_arbiter #(.ADDR_W(16), .WAIT_CYCLES(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [7:0] sb[$];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Stored value = pattern XOR delta; 2-state deltas start at zero.
    bit [7:0] dlt0 [0:65535];
    bit [7:0] dlt2 [0:65535];

    always @(posedge clk) begin
        if (b0.mem_en) begin
            if (b0.mem_we) dlt0[b0.mem_addr] <= b0.mem_wdata ^ pat(b0.mem_addr);
            b0.mem_rdata <= pat(b0.mem_addr) ^ dlt0[b0.mem_addr];
        end
        if (b2.mem_en) begin
            if (b2.mem_we) dlt2[b2.mem_addr] <= b2.mem_wdata ^ pat(b2.mem_addr);
            b2.mem_rdata <= pat(b2.mem_addr) ^ dlt2[b2.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("ack_excl0", 32'(b0.cpu_ack & b0.aes_xram_ack), 32'd0);
        chk("ack_excl2", 32'(b2.cpu_ack & b2.aes_xram_ack), 32'd0);
    end

    function automatic logic ack_of(input int sel);
        case (sel)
            0:       return b0.cpu_ack;
            1:       return b0.aes_xram_ack;
            2:       return b2.cpu_ack;
            default: return b2.aes_xram_ack;
        endcase
    endfunction

    function automatic logic [7:0] rdata_of(input int sel);
        case (sel)
            0:       return b0.cpu_rdata;
            1:       return b0.aes_xram_rdata;
            2:       return b2.cpu_rdata;
            default: return b2.aes_xram_rdata;
        endcase
    endfunction

    task automatic wait_ack(input int sel, input string tag, output int lat, output logic [7:0] rd);
        lat = 0;
        rd  = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ack_of(sel)) begin
                lat = i;
                rd  = rdata_of(sel);
                return;
            end
        end
        chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Single CPU transaction on the zero-wait instance, started and finished in IDLE.
    task automatic cpu0(input logic wr, input logic [15:0] a, input logic [7:0] d, input string tag);
        int lat;
        logic [7:0] rd;
        b0.cpu_addr  = a;
        b0.cpu_wdata = d;
        b0.cpu_wr    = wr;
        b0.cpu_stb   = 1'b1;
        if (!wr) sb.push_back(d);
        wait_ack(0, tag, lat, rd);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        if (!wr && lat != 0) chk({tag, "_rdata"}, 32'(rd), 32'(sb.pop_front()));
        b0.cpu_stb = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [7:0] rd;
        logic seen;
        logic [15:0] a;
        logic [1:0] exp_gnt;

        rst = 1'b1;
        b0.cpu_addr = '0; b0.cpu_wdata = '0; b0.cpu_wr = 1'b0; b0.cpu_stb = 1'b0;
        b0.aes_xram_addr = '0; b0.aes_xram_wdata = '0; b0.aes_xram_wr = 1'b0; b0.aes_xram_stb = 1'b0;
        b2.cpu_addr = '0; b2.cpu_wdata = '0; b2.cpu_wr = 1'b0; b2.cpu_stb = 1'b0;
        b2.aes_xram_addr = '0; b2.aes_xram_wdata = '0; b2.aes_xram_wr = 1'b0; b2.aes_xram_stb = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(b0.gnt), 32'd0);
        chk("rst_mem_en", 32'(b0.mem_en), 32'd0);
        chk("rst_mem_we", 32'(b0.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(b0.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(b0.mem_wdata), 32'd0);
        chk("rst_acks", 32'({b0.cpu_ack, b0.aes_xram_ack, b2.cpu_ack, b2.aes_xram_ack}), 32'd0);
        chk("rst_rdata", 32'({b0.cpu_rdata, b0.aes_xram_rdata}), 32'd0);
        rst = 1'b0;

        // CPU write A5 -> 0100, zero wait states, cycle by cycle.
        @(negedge clk);
        b0.cpu_addr = 16'h0100; b0.cpu_wdata = 8'hA5; b0.cpu_wr = 1'b1; b0.cpu_stb = 1'b1;
        @(negedge clk);
        chk("wr_mem_en", 32'(b0.mem_en), 32'd1);
        chk("wr_mem_we", 32'(b0.mem_we), 32'd1);
        chk("wr_mem_addr", 32'(b0.mem_addr), 32'h0100);
        chk("wr_mem_wdata", 32'(b0.mem_wdata), 32'hA5);
        chk("wr_gnt", 32'(b0.gnt), 32'd1);
        chk("wr_ack_early", 32'(b0.cpu_ack), 32'd0);
        @(negedge clk);
        chk("wr_ack", 32'(b0.cpu_ack), 32'd1);
        chk("wr_mem_en_off", 32'(b0.mem_en), 32'd0);
        chk("wr_aes_quiet", 32'({b0.aes_xram_ack, b0.aes_xram_rdata}), 32'd0);
        b0.cpu_stb = 1'b0;
        @(negedge clk);
        chk("wr_gnt_idle", 32'(b0.gnt), 32'd0);
        cpu0(1'b0, 16'h0100, 8'hA5, "rd_a5");

        // Simultaneous requests from reset: fixed priority or alternating grants.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b0.cpu_addr = 16'h0010; b0.cpu_wr = 1'b0; b0.cpu_stb = 1'b1;
            b0.aes_xram_addr = 16'h0020; b0.aes_xram_wr = 1'b0; b0.aes_xram_stb = 1'b1;
            @(negedge clk);
`ifdef XRAM_ARB_RR_EN
            exp_gnt = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_gnt = 2'b01;
`endif
            chk($sformatf("tie_gnt%0d", k), 32'(b0.gnt), 32'(exp_gnt));
            b0.cpu_stb = 1'b0;
            b0.aes_xram_stb = 1'b0;
            repeat (2) @(negedge clk);
        end

        // AES 16-byte read burst with two wait states.
        a = 16'h0200;
        b2.aes_xram_addr = a; b2.aes_xram_wr = 1'b0; b2.aes_xram_stb = 1'b1;
        for (int k = 0; k < 16; k++) begin
            sb.push_back(pat(a));
            wait_ack(3, "burst", lat, rd);
            chk($sformatf("burst_lat%0d", k), 32'(lat), (k == 0) ? 32'd4 : 32'd5);
            if (lat != 0) chk($sformatf("burst_rd%0d", k), 32'(rd), 32'(sb.pop_front()));
            if (k < 15) begin
                a = a + 16'd1;
                b2.aes_xram_addr = a;
            end else begin
                b2.aes_xram_stb = 1'b0;
            end
        end
        @(negedge clk);

        // CPU abandons a write during WAIT: no ack, data still lands.
        b2.cpu_addr = 16'h0300; b2.cpu_wdata = 8'h3C; b2.cpu_wr = 1'b1; b2.cpu_stb = 1'b1;
        repeat (2) @(negedge clk);
        chk("abn_gnt", 32'(b2.gnt), 32'd1);
        b2.cpu_stb = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | b2.cpu_ack;
        end
        chk("abn_no_ack", 32'(seen), 32'd0);
        chk("abn_ram", 32'(pat(16'h0300) ^ dlt2[16'h0300]), 32'h3C);
        b2.cpu_wr = 1'b0; b2.cpu_stb = 1'b1;
        sb.push_back(8'h3C);
        wait_ack(2, "abn_rd", lat, rd);
        chk("abn_rd_lat", 32'(lat), 32'd4);
        if (lat != 0) chk("abn_rd_data", 32'(rd), 32'(sb.pop_front()));
        b2.cpu_stb = 1'b0;
        @(negedge clk);

        // Reset pulsed during WAIT of an AES read, then the same request is served afresh.
        b2.aes_xram_addr = 16'h0205; b2.aes_xram_wr = 1'b0; b2.aes_xram_stb = 1'b1;
        @(negedge clk);
        chk("rstw_access", 32'(b2.mem_en), 32'd1);
        @(negedge clk);
        chk("rstw_wait_gnt", 32'(b2.gnt), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_gnt", 32'(b2.gnt), 32'd0);
        chk("rstw_mem_en", 32'(b2.mem_en), 32'd0);
        chk("rstw_ack", 32'(b2.aes_xram_ack), 32'd0);
        rst = 1'b0;
        sb.push_back(pat(16'h0205));
        wait_ack(3, "rstw_rd", lat, rd);
        chk("rstw_lat", 32'(lat), 32'd4);
        if (lat != 0) chk("rstw_data", 32'(rd), 32'(sb.pop_front()));
        b2.aes_xram_stb = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
